// File: rtl/alu_pkg.sv
// Shared picoMIPS ALU definitions: func codes, FSM state encoding, grant helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: func_t / RADD / RMUL (func code type and values),
//           state_t (arbiter FSM states), grant_onehot() (id -> 2-bit grant).
package alu_pkg;

    localparam int FW_PKG = 1;

    typedef logic [FW_PKG-1:0] func_t;

    localparam func_t RADD = 1'b0;
    localparam func_t RMUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Expand a requester index into its per-requester strobe bit.
    function automatic logic [1:0] grant_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational winner select between the two ALU requesters.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
//
// Ports: req_valid[1:0] requests in, last_grant previous winner (round-robin
//        build only), any_valid any request present, winner chosen index.
// Build option: ALU_ARB_FIXED_PRIO_EN selects fixed priority (requester 0
//        wins ties) and drops the last_grant input.
module alu_arb_pick
(
    input  logic [1:0] req_valid,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  logic       last_grant,
`endif
    output logic       any_valid,
    output logic       winner
);

    assign any_valid = |req_valid;

    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        // Requester 0 always wins when present; requester 1 can starve.
        winner = ~req_valid[0];
`else
        // On a tie the requester that did not win last time goes next;
        // with a single request present it wins regardless of history.
        if (&req_valid) begin
            winner = ~last_grant;
        end else begin
            winner = req_valid[1];
        end
`endif
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational picoMIPS ALU between the core (port 0) and self-test engine (port 1).
// Latency: accept in cycle T, response valid in cycle T+2; minimum 3 cycles per operation.
// Backpressure: response held in RESP until rsp_ready of the granted port; no accepts meanwhile.
//
// Ports: clk/nReset (sync, active-low); req_valid/req_ready plus req{0,1}_a/_b/_func
//        request handshake; rsp_valid/rsp_ready/rsp_result response handshake;
//        alu_a/alu_b/alu_func to the ALU, alu_result from the ALU.
// Build option: ALU_ARB_FIXED_PRIO_EN = fixed priority, otherwise round-robin.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N  = 8,
    parameter int FW = 1
)
(
    input  logic          clk,
    input  logic          nReset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [N-1:0]  req0_a,
    input  logic [N-1:0]  req1_a,
    input  logic [N-1:0]  req0_b,
    input  logic [N-1:0]  req1_b,
    input  logic [FW-1:0] req0_func,
    input  logic [FW-1:0] req1_func,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output logic [N-1:0]  rsp_result,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [FW-1:0] alu_func,
    input  logic [N-1:0]  alu_result
);

    state_t        state;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [FW-1:0] op_func;
    logic [N-1:0]  res;
    logic          grant_id;
    logic          any_valid;
    logic          winner;
    logic          accept;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic          last_grant;
`endif

    alu_arb_pick u_pick (
        .req_valid  (req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .last_grant (last_grant),
`endif
        .any_valid  (any_valid),
        .winner     (winner)
    );

    assign accept = (state == IDLE) && any_valid;

    // Handshake strobes are masked while nReset is low so nothing is
    // offered or accepted during the reset cycles themselves.
    assign req_ready  = (accept && nReset)            ? grant_onehot(winner)   : 2'b00;
    assign rsp_valid  = ((state == RESP) && nReset)   ? grant_onehot(grant_id) : 2'b00;
    assign rsp_result = res;

    // The operand registers only change on an accepting edge, so the ALU
    // inputs sit still outside EXEC and the ALU does not toggle needlessly.
    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign alu_func = op_func;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            op_func  <= FW'(RADD);
            res      <= '0;
            grant_id <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a     <= winner ? req1_a    : req0_a;
                        op_b     <= winner ? req1_b    : req0_b;
                        op_func  <= winner ? req1_func : req0_func;
                        grant_id <= winner;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= winner;
`endif
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    res   <= alu_result;
                    state <= RESP;
                end
                RESP: begin
                    // Only the granted port's ready matters; returning to
                    // IDLE here is what forces the one-cycle bubble.
                    if (rsp_ready[grant_id]) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 8;
    localparam int FW = 1;

    logic          clk = 1'b0;
    logic          nReset = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [N-1:0]  req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
    logic [FW-1:0] req0_func = RADD, req1_func = RADD;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready = 2'b11;
    logic [N-1:0]  rsp_result;
    logic [N-1:0]  alu_a, alu_b;
    logic [FW-1:0] alu_func;
    logic [N-1:0]  alu_result;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the external combinational ALU.
    logic [15:0] alu_prod;
    logic [8:0]  alu_sum;
    assign alu_prod   = alu_a * alu_b;
    assign alu_sum    = alu_a + alu_b;
    assign alu_result = (alu_func == RMUL) ? alu_prod[7:0] : alu_sum[7:0];

    alu_arbiter #(.N(N), .FW(FW)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req1_a     (req1_a),
        .req0_b     (req0_b),
        .req1_b     (req1_b),
        .req0_func  (req0_func),
        .req1_func  (req1_func),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_result (alu_result)
    );

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic f);
        logic [15:0] p;
        logic [8:0]  s;
        p = a * b;
        s = a + b;
        return (f == RMUL) ? p[7:0] : s[7:0];
    endfunction

    // Scoreboard: expected result pushed on each accepted request,
    // popped and compared when the response handshake completes.
    typedef struct { int id; logic [7:0] res; int cyc; } exp_t;
    exp_t exp_q[$];
    exp_t e_new, e_got;
    logic [1:0] prev_rsp = 2'b00;

    always @(negedge clk) begin
        if (!nReset) begin
            exp_q.delete();
            prev_rsp = 2'b00;
        end else begin
            if ((req_valid & req_ready) != 2'b00) begin
                if (req_valid[0] && req_ready[0]) begin
                    e_new.id = 0; e_new.res = model(req0_a, req0_b, req0_func);
                end else begin
                    e_new.id = 1; e_new.res = model(req1_a, req1_b, req1_func);
                end
                e_new.cyc = cyc;
                exp_q.push_back(e_new);
            end
            if (rsp_valid != 2'b00 && prev_rsp == 2'b00) begin
                checks++;
                if (exp_q.size() == 0)
                    $display("FAIL sb_unexpected: rsp_valid=%b with no request outstanding", rsp_valid);
                else if (cyc !== exp_q[0].cyc + 2)
                    $display("FAIL sb_latency: rsp_valid in cycle %0d, required %0d", cyc, exp_q[0].cyc + 2);
                else
                    passed++;
            end
            if ((rsp_valid & rsp_ready) != 2'b00 && exp_q.size() != 0) begin
                e_got = exp_q.pop_front();
                checks++;
                if (rsp_valid !== grant_onehot(e_got.id[0]))
                    $display("FAIL sb_port: rsp_valid=%b, required %b", rsp_valid, grant_onehot(e_got.id[0]));
                else passed++;
                checks++;
                if (rsp_result !== e_got.res)
                    $display("FAIL sb_result: rsp_result=%h, required %h", rsp_result, e_got.res);
                else passed++;
            end
            prev_rsp = rsp_valid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic do_reset();
        req_valid = 2'b00;
        nReset = 1'b0;
        repeat (2) @(posedge clk);
        #1 nReset = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic f, output int t);
        bit got;
        got = 1'b0;
        t = -1;
        if (i == 0) begin req0_a = a; req0_b = b; req0_func = f; end
        else        begin req1_a = a; req1_b = b; req1_func = f; end
        req_valid[i] = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (req_ready[i]) begin got = 1'b1; t = cyc; end
            @(posedge clk); #1;
        end
        req_valid[i] = 1'b0;
        checks++;
        if (!got) $display("FAIL issue%0d: req_ready=%b, required bit %0d set within 20 cycles", i, req_ready, i);
        else passed++;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        req_valid = 2'b11;
        @(posedge clk); #1;
        checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: %b, required 00", req_ready); else passed++;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid: %b, required 00", rsp_valid); else passed++;
        checks++; if (rsp_result !== 8'h00) $display("FAIL reset_rsp_result: %h, required 00", rsp_result); else passed++;
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00) $display("FAIL reset_alu_ops: a=%h b=%h, required 00 00", alu_a, alu_b); else passed++;
        checks++; if (alu_func !== RADD) $display("FAIL reset_alu_func: %b, required %b", alu_func, RADD); else passed++;
        req_valid = 2'b00;
        @(posedge clk); #1 nReset = 1'b1;
    endtask

    task automatic test_basic_add();
        int t;
        issue(0, 8'h7a, 8'h08, RADD, t);
        @(posedge clk); #1;
        checks++; if (cyc !== t + 2 || rsp_valid !== 2'b01) $display("FAIL add_valid: rsp_valid=%b cyc=%0d, required 01 at %0d", rsp_valid, cyc, t + 2); else passed++;
        checks++; if (rsp_result !== 8'h82) $display("FAIL add_result: %h, required 82", rsp_result); else passed++;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b00) $display("FAIL add_done: rsp_valid=%b, required 00", rsp_valid); else passed++;
    endtask

    task automatic test_basic_mul();
        int t;
        issue(1, 8'h7a, 8'h08, RMUL, t);
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b10) $display("FAIL mul_valid: rsp_valid=%b, required 10", rsp_valid); else passed++;
        checks++; if (rsp_result !== 8'hd0) $display("FAIL mul_result: %h, required d0", rsp_result); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        int ids [4];
        int cycs [4];
        int want [4];
        int n;
`ifdef ALU_ARB_FIXED_PRIO_EN
        want = '{0, 0, 0, 0};
`else
        want = '{0, 1, 0, 1};
`endif
        do_reset();
        req0_a = 8'h03; req0_b = 8'h04; req0_func = RADD;
        req1_a = 8'h05; req1_b = 8'h06; req1_func = RMUL;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        n = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            #1;
            if (req_ready != 2'b00) begin
                ids[n] = req_ready[1] ? 1 : 0;
                cycs[n] = cyc;
                n++;
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        checks++; if (n !== 4) $display("FAIL cont_count: %0d grants, required 4", n); else passed++;
        for (int j = 0; j < n; j++) begin
            checks++;
            if (ids[j] !== want[j]) $display("FAIL cont_order%0d: grant %0d, required %0d", j, ids[j], want[j]);
            else passed++;
            if (j > 0) begin
                checks++;
                if (cycs[j] - cycs[j-1] !== 3) $display("FAIL cont_spacing%0d: %0d cycles, required 3", j, cycs[j] - cycs[j-1]);
                else passed++;
            end
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_backpressure();
        int t;
        logic [1:0] want_rdy;
`ifdef ALU_ARB_FIXED_PRIO_EN
        want_rdy = 2'b01;
`else
        want_rdy = 2'b10;
`endif
        rsp_ready = 2'b10;
        issue(0, 8'h10, 8'h20, RADD, t);
        @(posedge clk); #1;
        req0_a = 8'hee; req0_b = 8'h01; req0_func = RADD;
        req1_a = 8'h09; req1_b = 8'h0b; req1_func = RMUL;
        req_valid = 2'b11;
        #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_result !== 8'h30) $display("FAIL bp_first: valid=%b result=%h, required 01 30", rsp_valid, rsp_result); else passed++;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            checks++;
            if (rsp_valid !== 2'b01 || rsp_result !== 8'h30 || req_ready !== 2'b00)
                $display("FAIL bp_hold%0d: valid=%b result=%h req_ready=%b, required 01 30 00", k, rsp_valid, rsp_result, req_ready);
            else passed++;
        end
        rsp_ready = 2'b11;
        @(posedge clk); #2;
        checks++; if (req_ready !== want_rdy) $display("FAIL bp_resume: req_ready=%b, required %b", req_ready, want_rdy); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_withdrawn();
        int t;
        logic [1:0] want_rdy;
`ifdef ALU_ARB_FIXED_PRIO_EN
        want_rdy = 2'b01;
`else
        want_rdy = 2'b10;
`endif
        rsp_ready = 2'b10;
        issue(0, 8'h21, 8'h03, RMUL, t);
        @(posedge clk); #1;
        req1_a = 8'h44; req1_b = 8'h55; req1_func = RADD;
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b01) $display("FAIL wd_resp: req_ready=%b rsp_valid=%b, required 00 01", req_ready, rsp_valid); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(posedge clk); #2;
        checks++; if (req_ready !== 2'b00 || rsp_valid !== 2'b00) $display("FAIL wd_idle: req_ready=%b rsp_valid=%b, required 00 00", req_ready, rsp_valid); else passed++;
        req0_a = 8'h02; req0_b = 8'h02; req0_func = RADD;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== want_rdy) $display("FAIL wd_next_grant: req_ready=%b, required %b", req_ready, want_rdy); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset_mid();
        int t;
        issue(0, 8'h01, 8'h02, RADD, t);
        nReset = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b00) $display("FAIL rm_ready_in_reset: %b, required 00", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 2'b00;
        nReset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (rsp_valid !== 2'b00) $display("FAIL rm_no_rsp%0d: rsp_valid=%b, required 00", k, rsp_valid); else passed++;
            @(posedge clk); #1;
        end
        issue(0, 8'hff, 8'h01, RADD, t);
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_result !== 8'h00) $display("FAIL rm_wrap: valid=%b result=%h, required 01 00", rsp_valid, rsp_result); else passed++;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_basic_mul();
        test_contention();
        test_backpressure();
        test_withdrawn();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) $display("FAIL sb_drain: %0d responses outstanding, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
